// File: rtl/cvxif_result_buffer_if.sv
// cvxif_result_buffer_if: CV-X-IF result/commit types and the result buffer port bundle.
// slave modport faces the buffer, master modport faces the driver of the buffer.
package cvxif_pkg;
    localparam int X_ID_WIDTH  = 4;
    localparam int X_RFW_WIDTH = 32;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
        logic                   we;
        logic                   exc;
        logic [5:0]             exccode;
    } x_result_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  x_commit_kill;
    } x_commit_t;
endpackage

interface cvxif_result_buffer_if
    import cvxif_pkg::*;
#(
    parameter int Depth = 4
);
    logic                   in_valid_i;
    logic                   in_ready_o;
    x_result_t              in_result_i;
    logic                   commit_valid_i;
    x_commit_t              commit_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    x_result_t              out_result_o;
    logic [$clog2(Depth):0] count_o;
    logic                   overflow_o;

    modport slave (
        input  in_valid_i, in_result_i, commit_valid_i, commit_i, out_ready_i,
        output in_ready_o, out_valid_o, out_result_o, count_o, overflow_o
    );

    modport master (
        output in_valid_i, in_result_i, commit_valid_i, commit_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_result_o, count_o, overflow_o
    );
endinterface

// File: rtl/cvxif_result_buffer.sv
// cvxif_result_buffer: circular buffer of CV-X-IF results with kill filtering and overflow flag.
// Define CVXIF_RESULT_BUF_BYPASS_EN to forward a result straight through when the buffer is empty.
module cvxif_result_buffer
    import cvxif_pkg::*;
#(
    parameter int Depth   = 4,
    parameter int IdWidth = X_ID_WIDTH
) (
    input logic clk_i,
    input logic rst_ni,
    input logic clr_i,
    cvxif_result_buffer_if.slave bus
);
    localparam int PW = $clog2(Depth);

    x_result_t [Depth-1:0] r_mem;
    logic [Depth-1:0]      r_alive;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW:0]           r_count;
    logic                  r_overflow;

    x_result_t             w_head;
    x_result_t             w_out_result;
    logic [IdWidth-1:0]    w_kill_id;
    logic [Depth-1:0]      w_alive_nxt;
    logic                  w_kill;
    logic                  w_in_kill;
    logic                  w_nonempty;
    logic                  w_head_live;
    logic                  w_dead_head;
    logic                  w_bypass;
    logic                  w_out_valid;
    logic                  w_in_ready;
    logic                  w_push;
    logic                  w_pop;

    assign w_kill      = bus.commit_valid_i && bus.commit_i.x_commit_kill;
    assign w_kill_id   = bus.commit_i.id[IdWidth-1:0];
    assign w_in_kill   = w_kill && (bus.in_result_i.id[IdWidth-1:0] == w_kill_id);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_nonempty  = r_count != '0;
    assign w_head_live = w_nonempty && r_alive[r_rd_ptr] &&
                         !(w_kill && (w_head.id[IdWidth-1:0] == w_kill_id));
    assign w_dead_head = w_nonempty && !r_alive[r_rd_ptr];
    assign w_in_ready  = r_count < (PW+1)'(Depth);

`ifdef CVXIF_RESULT_BUF_BYPASS_EN
    assign w_bypass     = !w_nonempty && bus.in_valid_i && !w_in_kill;
    assign w_out_result = w_bypass ? bus.in_result_i : w_head;
`else
    assign w_bypass     = 1'b0;
    assign w_out_result = w_head;
`endif

    assign w_out_valid = w_head_live || w_bypass;
    // A bypassed result taken by the core the same cycle never occupies a slot.
    assign w_push = bus.in_valid_i && w_in_ready && !(w_bypass && bus.out_ready_i);
    assign w_pop  = (w_head_live && bus.out_ready_i) || w_dead_head;

    always_comb begin
        w_alive_nxt = r_alive;
        for (int i = 0; i < Depth; i++)
            if (w_kill && (r_mem[i].id[IdWidth-1:0] == w_kill_id)) w_alive_nxt[i] = 1'b0;
        if (w_push) w_alive_nxt[r_wr_ptr] = !w_in_kill;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem      <= '0;
            r_alive    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clr_i) begin
            r_alive    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.in_result_i;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
            r_alive <= w_alive_nxt;
            if (bus.in_valid_i && !w_in_ready) r_overflow <= 1'b1;
        end
    end

    always_comb begin
        bus.out_result_o    = w_out_result;
        bus.out_result_o.we = w_out_result.we && w_out_valid;
    end

    assign bus.out_valid_o = w_out_valid;
    assign bus.in_ready_o  = w_in_ready;
    assign bus.count_o     = r_count;
    assign bus.overflow_o  = r_overflow;
endmodule

// File: tb/tb_cvxif_result_buffer.sv
// tb_cvxif_result_buffer: directed stimulus with a scoreboard queue checked by a handshake monitor.
module tb_cvxif_result_buffer;
    import cvxif_pkg::*;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    logic clr_i  = 1'b0;
    int   checks = 0;
    int   errors = 0;
    x_result_t exp_q[$];

    always #5 clk = ~clk;

    cvxif_result_buffer_if #(.Depth(4)) bus ();

    cvxif_result_buffer #(.Depth(4), .IdWidth(X_ID_WIDTH)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .clr_i (clr_i),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic x_result_t mk(input int id, input int data);
        x_result_t r;
        r         = '0;
        r.id      = X_ID_WIDTH'(id);
        r.data    = X_RFW_WIDTH'(data);
        r.rd      = 5'(id + 1);
        r.we      = 1'b1;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input x_result_t r, input logic rdy);
        bus.in_valid_i  = v;
        bus.in_result_i = r;
        bus.out_ready_i = rdy;
    endtask

    task automatic kill(input logic v, input int id, input logic k);
        bus.commit_valid_i       = v;
        bus.commit_i.id          = X_ID_WIDTH'(id);
        bus.commit_i.x_commit_kill = k;
    endtask

    // Every accepted result must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        x_result_t e;
        if (rst_ni && bus.out_valid_o && bus.out_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got id 0x%0h data 0x%0h, expected none",
                         bus.out_result_o.id, bus.out_result_o.data);
            end else begin
                e = exp_q.pop_front();
                chk("result", 64'(bus.out_result_o), 64'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        drive(1'b0, '0, 1'b0);
        kill(1'b0, 0, 1'b0);
        #2;
        chk("rst_count", 64'(bus.count_o), 0);
        chk("rst_out_valid", 64'(bus.out_valid_o), 0);
        chk("rst_in_ready", 64'(bus.in_ready_o), 1);
        chk("rst_overflow", 64'(bus.overflow_o), 0);
        chk("rst_out_result", 64'(bus.out_result_o), 0);
        cyc();
        cyc();
        rst_ni = 1'b1;
        cyc();

        drive(1'b1, mk(2, 'h15), 1'b1);
        exp_q.push_back(mk(2, 'h15));
        #1;
`ifdef CVXIF_RESULT_BUF_BYPASS_EN
        chk("t1_same_cycle_valid", 64'(bus.out_valid_o), 1);
`else
        chk("t1_push_cycle_valid", 64'(bus.out_valid_o), 0);
`endif
        cyc();
        drive(1'b0, '0, 1'b1);
        #1;
`ifdef CVXIF_RESULT_BUF_BYPASS_EN
        chk("t1_next_valid", 64'(bus.out_valid_o), 0);
        chk("t1_next_count", 64'(bus.count_o), 0);
`else
        chk("t1_next_valid", 64'(bus.out_valid_o), 1);
        chk("t1_next_count", 64'(bus.count_o), 1);
`endif
        cyc();
        chk("t1_final_count", 64'(bus.count_o), 0);
        chk("t1_final_valid", 64'(bus.out_valid_o), 0);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mk(i, 'h100 + i), 1'b0);
            exp_q.push_back(mk(i, 'h100 + i));
            cyc();
        end
        drive(1'b0, '0, 1'b0);
        #1;
        chk("t2_full_in_ready", 64'(bus.in_ready_o), 0);
        chk("t2_full_count", 64'(bus.count_o), 4);
        chk("t2_no_overflow_yet", 64'(bus.overflow_o), 0);
        cyc();
        drive(1'b1, mk(4, 'h999), 1'b0);
        cyc();
        drive(1'b0, '0, 1'b0);
        #1;
        chk("t2_overflow_set", 64'(bus.overflow_o), 1);
        chk("t2_count_after_drop", 64'(bus.count_o), 4);
        bus.out_ready_i = 1'b1;
        repeat (4) cyc();
        chk("t2_drained_count", 64'(bus.count_o), 0);
        chk("t2_overflow_sticky", 64'(bus.overflow_o), 1);
        clr_i = 1'b1;
        cyc();
        clr_i = 1'b0;
        #1;
        chk("t2_clr_overflow", 64'(bus.overflow_o), 0);

        for (int i = 1; i < 4; i++) begin
            drive(1'b1, mk(i, 'h300 + i), 1'b0);
            cyc();
        end
        exp_q.push_back(mk(1, 'h301));
        exp_q.push_back(mk(3, 'h303));
        drive(1'b0, '0, 1'b1);
        kill(1'b1, 2, 1'b1);
        #1;
        chk("t3_head1_valid", 64'(bus.out_valid_o), 1);
        cyc();
        kill(1'b0, 0, 1'b0);
        #1;
        chk("t3_dead_head_hidden", 64'(bus.out_valid_o), 0);
        chk("t3_count_dead", 64'(bus.count_o), 2);
        cyc();
        chk("t3_head3_valid", 64'(bus.out_valid_o), 1);
        chk("t3_count_head3", 64'(bus.count_o), 1);
        cyc();
        chk("t3_final_count", 64'(bus.count_o), 0);

        drive(1'b1, mk(5, 'h55), 1'b0);
        cyc();
        drive(1'b0, '0, 1'b1);
        kill(1'b1, 5, 1'b1);
        #1;
        chk("t4_killed_head_valid", 64'(bus.out_valid_o), 0);
        chk("t4_count", 64'(bus.count_o), 1);
        cyc();
        kill(1'b0, 0, 1'b0);
        #1;
        chk("t4_dead_head_valid", 64'(bus.out_valid_o), 0);
        cyc();
        chk("t4_final_count", 64'(bus.count_o), 0);

        drive(1'b1, mk(6, 'h66), 1'b1);
        kill(1'b1, 6, 1'b0);
        exp_q.push_back(mk(6, 'h66));
        cyc();
        drive(1'b0, '0, 1'b1);
        kill(1'b0, 0, 1'b0);
        cyc();
        chk("t4b_nonkill_count", 64'(bus.count_o), 0);

        pushed = 0;
        for (int c = 0; c < 60 && pushed < 10; c++) begin
            if (bus.in_ready_o) begin
                drive(1'b1, mk(pushed, 'h200 + pushed), c[0]);
                exp_q.push_back(mk(pushed, 'h200 + pushed));
                pushed++;
            end else begin
                drive(1'b0, '0, c[0]);
            end
            cyc();
        end
        chk("t5_all_pushed", 64'(pushed), 10);
        drive(1'b0, '0, 1'b1);
        repeat (6) cyc();
        chk("t5_final_count", 64'(bus.count_o), 0);
        chk("t5_no_overflow", 64'(bus.overflow_o), 0);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(8 + i, 'h400 + i), 1'b0);
            cyc();
        end
        drive(1'b0, '0, 1'b0);
        #1;
        chk("t6_count_before", 64'(bus.count_o), 3);
        chk("t6_valid_before", 64'(bus.out_valid_o), 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(bus.out_valid_o), 0);
        chk("t6_rst_count", 64'(bus.count_o), 0);
        chk("t6_rst_in_ready", 64'(bus.in_ready_o), 1);
        cyc();
        rst_ni = 1'b1;
        cyc();
        chk("t6_after_count", 64'(bus.count_o), 0);

        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cvxif_result_buffer.md
# cvxif_result_buffer

Buffers CV-X-IF result transactions between the coprocessor result port and the core result interface. Stored results are held until the core accepts them with `x_result_ready`. Results of instructions killed through the commit interface are discarded. Provides the backpressure that the coprocessor side lacks, and flags overflow when it is ignored.

## Interface
- `Depth`, 4: number of buffered results; power of two, ≥2.
- `IdWidth`, `cvxif_pkg::X_ID_WIDTH`: width of the instruction id field compared on kill.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; asynchronous and active-low.
- `clr_i` in 1: synchronous clear; empties the buffer and clears `overflow_o`.
- `in_valid_i` in 1: upstream result valid.
- `in_ready_o` out 1: buffer can accept a result.
- `in_result_i` in `x_result_t`: upstream result (id, data, rd, we, exc, exccode).
- `commit_valid_i` in 1: commit interface valid.
- `commit_i` in `x_commit_t`: commit id and `x_commit_kill`.
- `out_valid_o` out 1: result presented to core.
- `out_ready_i` in 1: core accepts result.
- `out_result_o` out `x_result_t`: head result.
- `count_o` out $clog2(Depth)+1: number of occupied entries, dead entries included.
- `overflow_o` out 1: sticky; a result arrived while `in_ready_o` was 0.

## Operation
- Storage is a circular buffer with `wr_ptr` and `rd_ptr` ($clog2(Depth) bits each, wrapping Depth-1→0) and a `count` register.
- Each entry has an `alive` bit.
- Push: `in_valid_i && in_ready_o`.
  - Writes the entry at `wr_ptr` with `alive=1`.
  - Increments `wr_ptr`.
- `in_ready_o = (count < Depth)`. It depends on count only; a full buffer refuses a push even in a cycle that pops.
- Push attempt while full: the result is dropped, `overflow_o` is set, and pointers are unchanged.
- Kill event: `commit_valid_i && commit_i.x_commit_kill`.
  - Clears `alive` of every stored entry whose id equals `commit_i.id[IdWidth-1:0]`.
  - An entry pushed in the same cycle with a matching id is stored with `alive=0`.
- Non-kill commits (`x_commit_kill=0`) have no effect.
- Head is presented when `count!=0`, the head is alive, and there is no same-cycle kill matching the head id. In that case `out_valid_o=1`.
- `out_result_o` = head entry. `out_result_o.we` is ANDed with `out_valid_o`.
- Pop happens on either of:
  - the handshake `out_valid_o && out_ready_i`, or
  - a dead head (`count!=0`, `alive=0`), which is discarded automatically without being presented. One entry is discarded per cycle.
- Count update: push only → count+1; pop only → count−1; push and pop together → count unchanged.
- `clr_i` overrides everything:
  - pointers, count and all `alive` bits go to 0;
  - `overflow_o` goes to 0;
  - a push in the same cycle is ignored.

## Timing
- Reset values:
  - `wr_ptr=rd_ptr=0`, `count_o=0`, all `alive=0`;
  - `overflow_o=0`, `out_valid_o=0`, `in_ready_o=1`, `out_result_o='0`.
- Latency: a pushed result is presented no earlier than the cycle after the push. It is presented exactly the next cycle if the buffer was empty (macro off).
- `out_valid_o` is combinational from registered state plus the same-cycle kill. `out_valid_o`, once high, stays high until the handshake unless a kill removes the head.
- `in_ready_o` is a function of registered `count` only; there is no combinational path from `out_ready_i`.
- `overflow_o` is set in the cycle after the dropped push. It stays set until `clr_i` or reset.
- Asynchronous reset mid-transfer discards all contents immediately.

## Configuration
- `CVXIF_RESULT_BUF_BYPASS_EN` defined: when `count==0`, `in_valid_i=1` and the incoming id is not killed that cycle:
  - `out_valid_o=1` and `out_result_o=in_result_i` in the same cycle;
  - if `out_ready_i=1`, the result is consumed with no write and the state is unchanged;
  - otherwise the result is pushed normally.
- Undefined: there is no combinational path from `in_*` to `out_*`; minimum latency is 1 cycle.

## Test plan
- Single result (id=2, data=0x15, we=1) pushed with `out_ready_i=1`:
  - macro off: `out_valid_o` high exactly 1 cycle later with data 0x15 and `count_o` returning to 0;
  - macro on: `out_valid_o` high in the same cycle as the push.
- Fill 4 results (ids 0–3) with `out_ready_i=0`:
  - `in_ready_o=0` and `count_o=4`;
  - a 5th push sets `overflow_o`;
  - draining then returns data in order 0,1,2,3;
  - `clr_i` clears `overflow_o`.
- Push ids 1,2,3, then kill id 2 while the head is id 1 with `out_ready_i=1`:
  - core receives ids 1 and 3 only;
  - id 2 is auto-dropped and `count_o` reaches 0.
- Kill matching the head id in the same cycle as `out_ready_i=1`: `out_valid_o=0` that cycle and no handshake occurs.
- Wrap-around: 10 back-to-back push/pop pairs at Depth=4 with `out_ready_i` toggling every cycle → all 10 results delivered in order, no overflow.
- Assert `rst_ni` low for one cycle with 3 entries stored → `out_valid_o=0` and `count_o=0` immediately, `in_ready_o=1`.
